multichannel_capture_buffer: RTL

Single-clock successor to the dual-clock input buffer: captures `LENGTH` simultaneous samples from `NSINK` signed channels into on-chip memory on a trigger, keeping up to `PRETRIG` samples from before the trigger, then streams the record out as one Avalon-ST packet per channel. Unlike its predecessor it supports source backpressure (`source_ready`), tags each beat with a channel number, accepts a sample-rate strobe instead of a dedicated sink clock, and flags triggers lost while draining. It sits between the ADC front-end samplers and the FFT/processing chain.

---
 rtl/capture_buffer_pkg.sv | 22 ++
 rtl/sdp_ram.sv | 27 ++
 rtl/multichannel_capture_buffer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/capture_buffer_pkg.sv
// Shared definitions for the multichannel capture buffer.
//   state_t  : controller states (ARMED, CAPTURE, DRAIN)
//   chan_w   : width of the channel tag for a given channel count
//   wrap_inc : address increment that wraps at an arbitrary depth
package capture_buffer_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Depth need not be a power of two, so the wrap is explicit.
  function automatic int wrap_inc(input int addr, input int len);
    return (addr >= len - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM with a registered read port.
//   clk   : clock
//   we    : write enable, waddr/wdata written at the rising edge
//   re    : read enable, rdata updated from raddr at the rising edge
//   rdata : read word, one cycle after the read request
module sdp_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/multichannel_capture_buffer.sv
// Triggered multichannel capture buffer. While armed, all channels are
// written continuously into a circular record memory, keeping up to PRETRIG
// pre-trigger samples. A trigger completes a LENGTH-sample record, which is
// then streamed out as one packet per channel, oldest sample first.
//   clk, reset     : clock, asynchronous active-high reset
//   sink_valid     : sample strobe for all channels
//   sink_start     : trigger, qualified by sink_valid
//   sink_data      : per-channel signed samples
//   source_ready   : downstream ready (readyLatency 0)
//   source_valid/sop/eop/channel/data : output stream
//   busy           : record in CAPTURE or DRAIN
//   overrun        : sticky, trigger seen while draining
module multichannel_capture_buffer
  import capture_buffer_pkg::*;
#(
  parameter int NSINK   = 3,
  parameter int WIDTH   = 14,
  parameter int LENGTH  = 2048,
  parameter int PRETRIG = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 sink_valid,
  input  logic                                 sink_start,
  input  logic signed [NSINK-1:0][WIDTH-1:0]   sink_data,
  input  logic                                 source_ready,
  output logic                                 source_valid,
  output logic                                 source_sop,
  output logic                                 source_eop,
  output logic [chan_w(NSINK)-1:0]             source_channel,
  output logic signed [WIDTH-1:0]              source_data,
  output logic                                 busy,
  output logic                                 overrun
);

  localparam int AW = $clog2(LENGTH);
  localparam int CW = chan_w(NSINK);
  localparam logic [AW-1:0] LAST    = AW'(LENGTH - 1);
  localparam logic [AW-1:0] PRE     = AW'(PRETRIG);
  localparam logic [CW-1:0] LAST_CH = CW'(NSINK - 1);

  state_t state, state_nx;
  logic [AW-1:0] wptr, fill, remaining, rd_addr, rd_beat;
  logic [AW-1:0] start_addr, remaining_init;
  logic [CW-1:0] rd_chan;
  logic          rd_done, trig, wr_en, rd_en, pop, last_xfer;

  logic                        vld_p1, sop_p1, eop_p1;
  logic [CW-1:0]               chan_p1;
  logic [NSINK-1:0][WIDTH-1:0] word_p1;
  logic signed [WIDTH-1:0]     data_p1;

  logic                    h_vld, t_vld, h_vld_nx, t_vld_nx;
  logic                    load_head, head_from_tail, load_tail;
  logic                    h_sop, h_eop, t_sop, t_eop;
  logic [CW-1:0]           h_chan, t_chan;
  logic signed [WIDTH-1:0] h_data, t_data;

  // Oldest retained sample; the trigger sample itself is post-trigger.
  assign start_addr     = AW'((int'(wptr) + LENGTH - int'(fill)) % LENGTH);
  assign remaining_init = AW'(LENGTH - 1 - int'(fill));

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    trig     = 1'b0;
    case (state)
      ARMED: begin
        wr_en = sink_valid;
        trig  = sink_valid & sink_start;
        if (trig) state_nx = (remaining_init == '0) ? DRAIN : CAPTURE;
      end
      CAPTURE: begin
        wr_en = sink_valid;
        if (sink_valid && remaining == AW'(1)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (last_xfer) state_nx = ARMED;
      end
      default: state_nx = ARMED;
    endcase
  end

  assign pop       = h_vld & source_ready;
  assign last_xfer = pop & h_eop & (h_chan == LAST_CH);

  // Issue a read only if its result is guaranteed a slot in the 2-entry
  // skid buffer, counting the in-flight read and this cycle's transfer.
  assign rd_en = (state == DRAIN) && !rd_done &&
                 ((int'(h_vld) + int'(t_vld) + int'(vld_p1) - int'(pop)) < 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARMED;
      wptr      <= '0;
      fill      <= '0;
      remaining <= '0;
      rd_addr   <= '0;
      rd_beat   <= '0;
      rd_chan   <= '0;
      rd_done   <= 1'b0;
      overrun   <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      state  <= state_nx;
      vld_p1 <= rd_en;
      if (wr_en) wptr <= AW'(wrap_inc(int'(wptr), LENGTH));
      if (trig) begin
        remaining <= remaining_init;
        rd_addr   <= start_addr;
        rd_beat   <= '0;
        rd_chan   <= '0;
        rd_done   <= 1'b0;
      end else if (state == ARMED && sink_valid && fill != PRE) begin
        fill <= fill + AW'(1);
      end
      if (state == CAPTURE && sink_valid) remaining <= remaining - AW'(1);
      if (state == DRAIN && sink_valid && sink_start) overrun <= 1'b1;
      if (last_xfer) fill <= '0;
      // LENGTH reads from the record start wrap back onto it, so each
      // channel pass starts at the right address without reloading.
      if (rd_en) begin
        rd_addr <= AW'(wrap_inc(int'(rd_addr), LENGTH));
        if (rd_beat == LAST) begin
          rd_beat <= '0;
          if (rd_chan == LAST_CH) rd_done <= 1'b1;
          else                    rd_chan <= rd_chan + CW'(1);
        end else begin
          rd_beat <= rd_beat + AW'(1);
        end
      end
    end
  end

  sdp_ram #(
    .DEPTH (LENGTH),
    .DW    (NSINK * WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (sink_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (word_p1)
  );

  // ---- p1: RAM word available, beat tags follow the read ----
  always_ff @(posedge clk) begin
    if (rd_en) begin
      sop_p1  <= (rd_beat == '0);
      eop_p1  <= (rd_beat == LAST);
      chan_p1 <= rd_chan;
    end
  end

  assign data_p1 = word_p1[chan_p1];

  // ---- p2: two-entry skid buffer, head drives the source port ----
  always_comb begin
    load_head      = 1'b0;
    head_from_tail = 1'b0;
    load_tail      = 1'b0;
    h_vld_nx       = h_vld;
    t_vld_nx       = t_vld;
    if (pop) begin
      if (t_vld) begin
        load_head      = 1'b1;
        head_from_tail = 1'b1;
        load_tail      = vld_p1;
        t_vld_nx       = vld_p1;
      end else begin
        load_head = vld_p1;
        h_vld_nx  = vld_p1;
      end
    end else if (vld_p1) begin
      if (h_vld) begin
        load_tail = 1'b1;
        t_vld_nx  = 1'b1;
      end else begin
        load_head = 1'b1;
        h_vld_nx  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_vld  <= 1'b0;
      t_vld  <= 1'b0;
      h_sop  <= 1'b0;
      h_eop  <= 1'b0;
      h_chan <= '0;
      h_data <= '0;
    end else begin
      h_vld <= h_vld_nx;
      t_vld <= t_vld_nx;
      if (load_head) begin
        if (head_from_tail) begin
          h_sop  <= t_sop;
          h_eop  <= t_eop;
          h_chan <= t_chan;
          h_data <= t_data;
        end else begin
          h_sop  <= sop_p1;
          h_eop  <= eop_p1;
          h_chan <= chan_p1;
          h_data <= data_p1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_tail) begin
      t_sop  <= sop_p1;
      t_eop  <= eop_p1;
      t_chan <= chan_p1;
      t_data <= data_p1;
    end
  end

  assign source_valid   = h_vld;
  assign source_sop     = h_sop;
  assign source_eop     = h_eop;
  assign source_channel = h_chan;
  assign source_data    = h_data;
  assign busy           = (state != ARMED);

endmodule
